datapath_seq: RTL
=================

# datapath_seq

Parametrised successor to the externally sequenced 16-bit datapath. It executes one micro-operation per request (fetch, ALU execute, load, store) through an internal sequencer, and talks to memory over a variable-latency req/ack handshake instead of assuming single-cycle memory. The block sits between the control unit, which issues operations, and the unified memory/IO bus. Width and register-file depth are parameters.

## Interface

Parameters:
- WIDTH, 16, datapath/address width; legal values are 16 or more.
- REGBITS, 4, register index bits; legal range 2..4; file holds 2**REGBITS registers.
- PC_RESET, 16'h0000, PC value after reset, zero-extended to WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  operation request.
- op_ready  out  1  high only in IDLE; an operation is accepted when op_valid && op_ready.
- op_kind  in  2  operation: 00 FETCH, 01 EXEC, 10 LOAD, 11 STORE.
- alu_op  in  3  EXEC function; sampled at accept.
- use_imm  in  1  EXEC source: 1 selects extended instr[7:0], 0 selects register rsrc.
- zero_ext  in  1  immediate extension: 1 zero-extends, 0 sign-extends.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, valid while mem_req is high.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  read data; valid in the cycle mem_ack is high.
- mem_ack  in  1  completes the current request.
- op_done  out  1  one-cycle completion pulse.
- instr  out  16  current instruction register.
- pc  out  WIDTH  program counter.
- psr  out  5  flags {N,Z,F,L,C} (bit 4 down to bit 0).

## Operation

- Instruction fields: rdest = instr[8 +: REGBITS]; rsrc = instr[0 +: REGBITS]. The immediate is instr[7:0], extended to WIDTH.
- States and transitions:
  - IDLE → MEM when the accepted op is FETCH, LOAD or STORE; IDLE → EXEC when it is EXEC.
  - MEM → DONE on mem_ack.
  - EXEC → DONE unconditionally.
  - DONE → IDLE unconditionally.
- The op fields (op_kind, alu_op, use_imm, zero_ext) are latched at accept.
- MEM behaviour by operation:
  - FETCH: address = pc. On ack, instr ← mem_rdata[15:0] and pc ← pc+1 (wraps modulo 2**WIDTH).
  - LOAD: address = R[rsrc]. On ack, R[rdest] ← mem_rdata.
  - STORE: address = R[rsrc], mem_we=1, mem_wdata = R[rdest].
- EXEC: A = R[rdest], B = source. Results are written to R[rdest] at the end of the EXEC cycle.
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND, 011 OR, 100 XOR: bitwise.
  - 101 MOV: B.
  - 110 CMP: flags only; no register write.
  - 111 LSH: A shifted by B[$clog2(WIDTH):0] taken as signed. Positive shifts left; negative shifts right logically. A magnitude ≥ WIDTH gives 0.
- Flags:
  - ADD: C = carry out; F = signed overflow.
  - SUB/CMP: C = unsigned borrow (A<B); L = unsigned A<B; N = signed A<B; F = signed overflow.
  - Z = (result==0) for every op except CMP, where Z = (A==B).
  - Flags that an op does not define hold their previous value. LOAD, STORE and FETCH never change psr.
- Register file: 2**REGBITS × WIDTH, async-reset to 0, one write port. R0 is not special.

## Timing

- Reset values: state IDLE, op_ready=1, op_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr=0, psr=0, pc=PC_RESET, all registers 0.
- Accept in cycle T.
  - EXEC: op_done in T+2; the result is visible in R and psr from T+2.
  - Memory ops: mem_req rises in T+1. mem_addr, mem_we and mem_wdata stay stable until mem_ack is sampled high. With ack in cycle T+1+k (k≥0), op_done is in T+2+k and mem_req is 0 from T+2+k.
- op_ready is 0 from T+1 until the cycle after op_done. Back-to-back ops therefore start no faster than every 3 cycles.
- op_valid outside IDLE is ignored; the request is not queued.
- mem_ack outside MEM is ignored.
- An ack held high for several cycles completes only one request.
- Reset mid-operation: all state returns to reset values asynchronously; mem_req drops in the same cycle. A write in flight is abandoned, and no register or psr update occurs.

## Structure

- Shared package datapath_pkg:
  - op_kind encodings
  - alu_op encodings
  - state enum {IDLE, MEM, EXEC, DONE}
  - PSR bit indices PSR_C=0, PSR_L=1, PSR_F=2, PSR_Z=3, PSR_N=4
- Sub-module dp_alu: combinational, parametrised by WIDTH; inputs A, B, alu_op, prior psr; outputs result, next psr. The sequencer, register file and memory interface stay in datapath_seq.

## Test plan

- Reset, then FETCH with mem_rdata=16'h2105 and ack after 3 wait cycles → instr=16'h2105, pc=1, op_done in T+5, mem_req high for exactly 4 cycles.
- R1=16'h7FFF; EXEC ADD, use_imm=1, instr[7:0]=8'h01, sign extension → R1=16'h8000, F=1, N unchanged, C=0, Z=0.
- EXEC CMP with R1=5, src=16'hFFFF, register source → L=1, N=0, C=1, Z=0, R1 unchanged.
- LSH R2=16'h00F0 with B=−4 → 16'h000F; with B=16 → 16'h0000, Z=1.
- STORE R3=16'hBEEF to address R4=16'hCFFD with ack held high for 3 cycles → exactly one write, mem_wdata=16'hBEEF, one op_done.
- Assert reset while in MEM with mem_req=1 → mem_req=0 the same cycle, pc=PC_RESET, op_ready=1; op_valid pulsed during EXEC is ignored.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared encodings for the sequenced datapath: operation kinds, ALU functions,
// sequencer states and PSR flag positions.
package datapath_pkg;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_EXEC  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } op_kind_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_MOV = 3'b101,
    ALU_CMP = 3'b110,
    ALU_LSH = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MEM  = 2'b01,
    EXEC = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int PSR_C    = 0;
  localparam int PSR_L    = 1;
  localparam int PSR_F    = 2;
  localparam int PSR_Z    = 3;
  localparam int PSR_N    = 4;
  localparam int PSR_BITS = 5;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: computes the EXEC result and the next PSR, holding any
// flag the selected function does not define.
module dp_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  alu_op_e             op_i,
  input  logic [PSR_BITS-1:0] psr_i,
  output logic [WIDTH-1:0]    result_o,
  output logic [PSR_BITS-1:0] psr_o
);

  // Shift amount is a signed field one bit wider than needed to index WIDTH.
  localparam int SHW = $clog2(WIDTH) + 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt;
  logic [SHW-1:0]   sh_amt;
  logic [SHW-1:0]   sh_mag;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    diff    = {1'b0, a_i} - {1'b0, b_i};
    add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
    slt     = $signed(a_i) < $signed(b_i);

    sh_amt = b_i[SHW-1:0];
    sh_mag = sh_amt[SHW-1] ? -sh_amt : sh_amt;
    if (int'(sh_mag) >= WIDTH) begin
      shifted = '0;
    end else if (sh_amt[SHW-1]) begin
      shifted = a_i >> sh_mag;
    end else begin
      shifted = a_i << sh_mag;
    end

    result_o = '0;
    psr_o    = psr_i;
    case (op_i)
      ALU_ADD: begin
        result_o     = sum[WIDTH-1:0];
        psr_o[PSR_C] = sum[WIDTH];
        psr_o[PSR_F] = add_ovf;
      end
      ALU_SUB, ALU_CMP: begin
        result_o     = diff[WIDTH-1:0];
        psr_o[PSR_C] = diff[WIDTH];
        psr_o[PSR_L] = diff[WIDTH];
        psr_o[PSR_N] = slt;
        psr_o[PSR_F] = sub_ovf;
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_MOV: result_o = b_i;
      ALU_LSH: result_o = shifted;
      default: result_o = '0;
    endcase
    psr_o[PSR_Z] = (op_i == ALU_CMP) ? (a_i == b_i) : (result_o == '0);
  end

endmodule

// File: rtl/datapath_seq.sv
// Sequenced datapath: accepts one micro-operation at a time and runs it through
// IDLE -> MEM/EXEC -> DONE, using a req/ack memory handshake of any latency.
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int          WIDTH    = 16,
  parameter int          REGBITS  = 4,
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_kind,
  input  logic [2:0]       alu_op,
  input  logic             use_imm,
  input  logic             zero_ext,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             op_done,
  output logic [15:0]      instr,
  output logic [WIDTH-1:0] pc,
  output logic [4:0]       psr
);

  localparam int NREGS = 2 ** REGBITS;

  state_e              state_q;
  op_kind_e            kind_q;
  alu_op_e             alu_op_q;
  logic                use_imm_q;
  logic                zero_ext_q;
  logic                ready_q;
  logic                done_q;
  logic                req_q;
  logic                we_q;
  logic [WIDTH-1:0]    addr_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [15:0]         instr_q;
  logic [WIDTH-1:0]    pc_q;
  logic [PSR_BITS-1:0] psr_q;
  logic [WIDTH-1:0]    regs_q [NREGS];

  op_kind_e            kind_in;
  logic [REGBITS-1:0]  rdest;
  logic [REGBITS-1:0]  rsrc;
  logic [WIDTH-1:0]    imm_ext;
  logic [WIDTH-1:0]    src_b;
  logic [WIDTH-1:0]    alu_result;
  logic [PSR_BITS-1:0] alu_psr;
  logic                rf_we;
  logic [WIDTH-1:0]    rf_wdata;

  assign kind_in = op_kind_e'(op_kind);
  assign rdest   = instr_q[8 +: REGBITS];
  assign rsrc    = instr_q[0 +: REGBITS];
  assign imm_ext = zero_ext_q ? {{(WIDTH-8){1'b0}}, instr_q[7:0]}
                              : {{(WIDTH-8){instr_q[7]}}, instr_q[7:0]};
  assign src_b   = use_imm_q ? imm_ext : regs_q[rsrc];

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i      (regs_q[rdest]),
    .b_i      (src_b),
    .op_i     (alu_op_q),
    .psr_i    (psr_q),
    .result_o (alu_result),
    .psr_o    (alu_psr)
  );

  // Single write port shared by LOAD completion and non-CMP EXEC results.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_result;
    if (state_q == MEM && mem_ack && kind_q == OP_LOAD) begin
      rf_we    = 1'b1;
      rf_wdata = mem_rdata;
    end else if (state_q == EXEC && alu_op_q != ALU_CMP) begin
      rf_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rdest] <= rf_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      kind_q     <= OP_FETCH;
      alu_op_q   <= ALU_ADD;
      use_imm_q  <= 1'b0;
      zero_ext_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      instr_q    <= '0;
      pc_q       <= WIDTH'(PC_RESET);
      psr_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            kind_q     <= kind_in;
            alu_op_q   <= alu_op_e'(alu_op);
            use_imm_q  <= use_imm;
            zero_ext_q <= zero_ext;
            ready_q    <= 1'b0;
            if (kind_in == OP_EXEC) begin
              state_q <= EXEC;
            end else begin
              // Address and store data are captured here so they stay stable
              // for however long the memory takes to acknowledge.
              state_q <= MEM;
              req_q   <= 1'b1;
              we_q    <= (kind_in == OP_STORE);
              addr_q  <= (kind_in == OP_FETCH) ? pc_q : regs_q[rsrc];
              if (kind_in == OP_STORE) wdata_q <= regs_q[rdest];
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
            if (kind_q == OP_FETCH) begin
              instr_q <= mem_rdata[15:0];
              pc_q    <= pc_q + WIDTH'(1);
            end
          end
        end
        EXEC: begin
          psr_q   <= alu_psr;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ready  = ready_q;
  assign op_done   = done_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign psr       = psr_q;

endmodule
